// File: rtl/hpss_frame_sched_if.sv
// hpss_frame_sched_if
// Start/done handshake bundle between the HPSS frame scheduler and the
// processing stages it sequences.
//   frame_ready  : capture block -> scheduler, one-cycle frame-captured pulse
//   fft_finish   : forward FFT -> scheduler, stage complete
//   h_done       : harmonic median filter -> scheduler, stage complete
//   p_done       : percussive median filter -> scheduler, stage complete
//   ifft_finish  : mask/iFFT -> scheduler, stage complete
//   out_done     : output stage -> scheduler, iFFT buffer drained
//   fft_start    : scheduler -> forward FFT, one-cycle start
//   med_start    : scheduler -> both median filters, one-cycle start
//   ifft_start   : scheduler -> mask/iFFT, one-cycle start
//   out_start    : scheduler -> output stage, one-cycle start
// modport master is the scheduler side; modport slave is the stage side.
interface hpss_frame_sched_if;
  logic frame_ready;
  logic fft_finish;
  logic h_done;
  logic p_done;
  logic ifft_finish;
  logic out_done;
  logic fft_start;
  logic med_start;
  logic ifft_start;
  logic out_start;

  modport master (
    input  frame_ready, fft_finish, h_done, p_done, ifft_finish, out_done,
    output fft_start, med_start, ifft_start, out_start
  );

  modport slave (
    output frame_ready, fft_finish, h_done, p_done, ifft_finish, out_done,
    input  fft_start, med_start, ifft_start, out_start
  );
endinterface

// File: rtl/hpss_frame_sched.sv
// hpss_frame_sched
// Per-frame scheduler for the HPSS separation chain. Queues captured-frame
// notifications and runs one frame at a time through FFT -> median filters
// -> masked iFFT -> output drain, with a per-stage watchdog.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : scheduling enable, only looked at in IDLE
//   hs           : start/done handshake bundle (master side)
//   busy         : FSM not in IDLE
//   state        : current state code
//   pending      : queued frames not yet started
//   frame_id     : completed-frame counter (wraps)
//   drop_pulse   : one-cycle pulse when a frame_ready hit a full queue
//   drop_cnt     : saturating drop counter
//   timeout_err  : one-cycle pulse on watchdog expiry
//   err_stage    : state code of the last stage that timed out
//
// state | meaning
// IDLE  | waiting for en and a queued frame
// FFT   | forward FFT running
// MED   | harmonic and percussive median filters running in parallel
// IFFT  | masked iFFT running
// OUT   | output stage draining the iFFT buffer
module hpss_frame_sched #(
  parameter int PEND_MAX    = 2,
  parameter int TIMEOUT_CYC = 20000,
  parameter int TO_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  hpss_frame_sched_if.master   hs,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [2:0]           pending,
  output logic [15:0]          frame_id,
  output logic                 drop_pulse,
  output logic [7:0]           drop_cnt,
  output logic                 timeout_err,
  output logic [2:0]           err_stage
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FFT  = 3'd1,
    ST_MED  = 3'd2,
    ST_IFFT = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      pending_q, pending_d;
  logic [15:0]     frame_id_q, frame_id_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            drop_pulse_q, drop_pulse_d;
  logic            timeout_err_q, timeout_err_d;
  logic [2:0]      err_stage_q, err_stage_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            h_flag_q, h_flag_d;
  logic            p_flag_q, p_flag_d;
  logic            busy_q, busy_d;
  logic            fft_start_q, fft_start_d;
  logic            med_start_q, med_start_d;
  logic            ifft_start_q, ifft_start_d;
  logic            out_start_q, out_start_d;

  logic            done_acc;
  logic            expire;
  logic            deq;
  logic            entering;

  always_comb begin
    state_d       = state_q;
    done_acc      = 1'b0;
    h_flag_d      = h_flag_q;
    p_flag_d      = p_flag_q;

    unique case (state_q)
      ST_IDLE: if (en && pending_q != 3'd0) state_d = ST_FFT;
      ST_FFT: begin
        done_acc = hs.fft_finish;
        if (done_acc) state_d = ST_MED;
      end
      ST_MED: begin
        // Dones may arrive in any order; the flag plus the live input lets the
        // second done complete the stage in the cycle it arrives.
        h_flag_d = h_flag_q | hs.h_done;
        p_flag_d = p_flag_q | hs.p_done;
        done_acc = h_flag_d & p_flag_d;
        if (done_acc) state_d = ST_IFFT;
      end
      ST_IFFT: begin
        done_acc = hs.ifft_finish;
        if (done_acc) state_d = ST_OUT;
      end
      ST_OUT: begin
        done_acc = hs.out_done;
        if (done_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A done in the expiry cycle wins over the watchdog.
    expire = (state_q != ST_IDLE) && !done_acc && (wd_q == TO_W'(TIMEOUT_CYC - 1));
    if (expire) state_d = ST_IDLE;

    // Flags only live while in MED; dones seen elsewhere are not remembered.
    if (state_d != ST_MED) begin
      h_flag_d = 1'b0;
      p_flag_d = 1'b0;
    end

    entering = (state_d != state_q);
    wd_d     = entering ? '0 : ((state_q != ST_IDLE) ? wd_q + 1'b1 : wd_q);

    // Dequeue and enqueue on the same edge cancel; never counts as a drop.
    deq          = (state_q == ST_IDLE) && (state_d == ST_FFT);
    pending_d    = pending_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    if (hs.frame_ready && !deq) begin
      if (pending_q == 3'(PEND_MAX)) begin
        drop_pulse_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end else if (!hs.frame_ready && deq) begin
      pending_d = pending_q - 3'd1;
    end

    frame_id_d    = (state_q == ST_OUT && done_acc) ? frame_id_q + 16'd1 : frame_id_q;
    timeout_err_d = expire;
    err_stage_d   = expire ? state_q : err_stage_q;
    busy_d        = (state_d != ST_IDLE);

    fft_start_d   = entering && (state_d == ST_FFT);
    med_start_d   = entering && (state_d == ST_MED);
    ifft_start_d  = entering && (state_d == ST_IFFT);
    out_start_d   = entering && (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      frame_id_q    <= '0;
      drop_cnt_q    <= '0;
      drop_pulse_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      err_stage_q   <= '0;
      wd_q          <= '0;
      h_flag_q      <= 1'b0;
      p_flag_q      <= 1'b0;
      busy_q        <= 1'b0;
      fft_start_q   <= 1'b0;
      med_start_q   <= 1'b0;
      ifft_start_q  <= 1'b0;
      out_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      frame_id_q    <= frame_id_d;
      drop_cnt_q    <= drop_cnt_d;
      drop_pulse_q  <= drop_pulse_d;
      timeout_err_q <= timeout_err_d;
      err_stage_q   <= err_stage_d;
      wd_q          <= wd_d;
      h_flag_q      <= h_flag_d;
      p_flag_q      <= p_flag_d;
      busy_q        <= busy_d;
      fft_start_q   <= fft_start_d;
      med_start_q   <= med_start_d;
      ifft_start_q  <= ifft_start_d;
      out_start_q   <= out_start_d;
    end
  end

  assign hs.fft_start  = fft_start_q;
  assign hs.med_start  = med_start_q;
  assign hs.ifft_start = ifft_start_q;
  assign hs.out_start  = out_start_q;
  assign busy          = busy_q;
  assign state         = state_q;
  assign pending       = pending_q;
  assign frame_id      = frame_id_q;
  assign drop_pulse    = drop_pulse_q;
  assign drop_cnt      = drop_cnt_q;
  assign timeout_err   = timeout_err_q;
  assign err_stage     = err_stage_q;

endmodule

// File: doc/hpss_frame_sched.md
# hpss_frame_sched

Per-frame scheduler for the HPSS separation chain. It queues captured-frame notifications and sequences the stages one frame at a time: forward FFT, then harmonic and percussive median filtering in parallel, then masked iFFT, then output drain. Start/done handshakes with each stage are guarded by a watchdog, and the block reports frame drops and stalls. It sits above the FFT, median-filter, mask/iFFT and output-buffer blocks and is their only source of start pulses.

## Interface
- PEND_MAX, 2: maximum queued frames not yet started (1..7).
- TIMEOUT_CYC, 20000: stage watchdog limit in cycles (≥4, < 2^TO_W).
- TO_W, 16: watchdog counter width.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduling enable; sampled only in IDLE.
- frame_ready  in  1  one-cycle pulse: 1024-sample input frame captured.
- fft_finish  in  1  forward FFT complete.
- h_done  in  1  harmonic median filter complete.
- p_done  in  1  percussive median filter complete.
- ifft_finish  in  1  masked iFFT complete.
- out_done  in  1  output stage has drained the iFFT buffer.
- fft_start  out  1  one-cycle start pulse to forward FFT.
- med_start  out  1  one-cycle start pulse to both median filters.
- ifft_start  out  1  one-cycle start pulse to mask/iFFT block.
- out_start  out  1  one-cycle start pulse to output stage.
- busy  out  1  FSM not in IDLE.
- state  out  3  IDLE=0, FFT=1, MED=2, IFFT=3, OUT=4.
- pending  out  3  queued frame count.
- frame_id  out  16  completed-frame counter, wraps 0xFFFF→0.
- drop_pulse  out  1  one-cycle pulse: frame_ready lost to full queue.
- drop_cnt  out  8  saturating drop count (stops at 255).
- timeout_err  out  1  one-cycle pulse on watchdog expiry.
- err_stage  out  3  state code of last timed-out stage; holds until next timeout.

## Operation
- Reset: every output 0; state IDLE; pending 0; done flags clear.
- Queue: frame_ready with pending<PEND_MAX → pending+1. frame_ready with pending=PEND_MAX → drop_pulse, drop_cnt+1 (saturating), pending unchanged. frame_ready in the same cycle as a dequeue → net pending unchanged; this case never counts as a drop, even at PEND_MAX.
- IDLE→FFT: when en=1 and pending>0; pending−1 on the same edge.
- FFT→MED: on fft_finish.
- MED: h_done and p_done each latch into a sticky flag and may arrive in any order or cycle. Leave MED when both flags are set, or when one is set and the other done arrives. Flags clear on exit from MED.
- MED→IFFT on both dones; IFFT→OUT on ifft_finish; OUT→IDLE on out_done, frame_id+1.
- A done input is accepted in any cycle of its own state, including the start-pulse cycle. Done inputs asserted in any other state are ignored and not remembered.
- Start pulse: high for exactly the first cycle after entering the stage state. Never re-asserted while staying in the state.
- Watchdog: TO_W-bit counter cleared on every state entry, incremented each cycle in FFT/MED/IFFT/OUT.
  - Expiry: in a stage's TIMEOUT_CYC-th cycle (counter = TIMEOUT_CYC−1) with no accepted done → timeout_err pulse, err_stage ← state, next state IDLE, frame abandoned (frame_id unchanged, MED flags cleared).
  - A done arriving in the expiry cycle wins: normal transition, no error.
- en=0 outside IDLE: current frame completes normally; the FSM then stays in IDLE and keeps queueing.
- Reset mid-frame: immediate return to reset values. No start pulse is generated by reset release.

## Timing
- Done-to-start latency: 1 cycle. Done sampled high at edge N → state changes at edge N → next start high during cycle N..N+1.
- frame_ready to fft_start (IDLE, en=1, pending=0): pending=1 after edge N; IDLE→FFT at edge N+1; fft_start high in cycle after edge N+1.
- Minimum frame period through the FSM: 5 cycles (IDLE + 4 stages, each done on its start cycle).
- All outputs registered; no combinational input→output paths.

## Test plan
- Single frame, TIMEOUT_CYC=64: frame_ready, then each done 10 cycles after its start → fft/med/ifft/out_start each pulse once, 11 cycles apart; frame_id 0→1; busy low afterwards.
- MED ordering: p_done at cycle 3 and h_done at cycle 20 of MED, then the swapped order → ifft_start exactly 1 cycle after the later done in both cases; a stray h_done during FFT is ignored.
- Queue overflow, PEND_MAX=2, en=0: 4 frame_ready pulses → pending=2, drop_cnt=2, two drop_pulses. Raise en → 2 complete frames, frame_id=2.
- Dequeue collision: pending=2, frame_ready on the IDLE→FFT edge → pending stays 2, no drop.
- Watchdog, TIMEOUT_CYC=64: withhold ifft_finish → timeout_err in the 64th IFFT cycle, err_stage=3, state IDLE, frame_id unchanged. Repeat with ifft_finish in that same cycle → state OUT, no error.
- Async reset asserted in MED with h flag set → all outputs 0 immediately. After release, a new frame requires both h_done and p_done.
